game_control_fsm: RTL

Top-level game sequencer that drives the logic handler's `startGameEn`, `shipUpdateEn` and `gridUpdateEn` strobes from user buttons and ship health. It debounces nothing. It edge-detects the start and pause buttons, holds the game-reset strobe for a programmable window, and generates the periodic ship-movement and bullet-grid update pulses from two free-running dividers. It detects game over when health reaches zero. It sits directly upstream of the logic handler and consumes that block's `ship_health` output.

---
 rtl/game_control_fsm_if.sv | 23 ++
 rtl/game_control_fsm.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/game_control_fsm_if.sv
// Button inputs, health feedback and update strobes between the game
// sequencer and its neighbours (buttons / logic handler).
// The master side drives buttons and health; the slave side is the sequencer.
interface game_control_fsm_if;
   logic       start;
   logic       pause;
   logic [3:0] ship_health;
   logic       startGameEn;
   logic       shipUpdateEn;
   logic       gridUpdateEn;
   logic       game_over;
   logic [2:0] state;

   modport master (
      output start, pause, ship_health,
      input  startGameEn, shipUpdateEn, gridUpdateEn, game_over, state
   );

   modport slave (
      input  start, pause, ship_health,
      output startGameEn, shipUpdateEn, gridUpdateEn, game_over, state
   );
endinterface

// File: rtl/game_control_fsm.sv
// Game sequencer: edge-detects the start/pause buttons, holds the game-reset
// strobe for START_CYCLES cycles, and produces the periodic ship-movement and
// bullet-grid update pulses from two dividers that only advance in PLAY.
// Game over is entered when the ship health reaches zero during PLAY.
module game_control_fsm #(
   parameter int START_CYCLES = 4,
   parameter int SHIP_DIV     = 833333,
   parameter int GRID_DIV     = 416666
) (
   input logic               clk,
   input logic               reset,
   game_control_fsm_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      PLAY  = 3'd2,
      PAUSE = 3'd3,
      OVER  = 3'd4
   } state_t;

   // start_cnt must hold START_CYCLES-1, which needs at least one bit even
   // when START_CYCLES is 1.
   localparam int START_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam int SHIP_W  = $clog2(SHIP_DIV);
   localparam int GRID_W  = $clog2(GRID_DIV);

   localparam logic [START_W-1:0] START_MAX = START_W'(START_CYCLES - 1);
   localparam logic [SHIP_W-1:0]  SHIP_MAX  = SHIP_W'(SHIP_DIV - 1);
   localparam logic [GRID_W-1:0]  GRID_MAX  = GRID_W'(GRID_DIV - 1);

   state_t              state;
   state_t              next_state;
   logic                start_q;
   logic                pause_q;
   logic                start_rise;
   logic                pause_rise;
   logic [START_W-1:0]  start_cnt;
   logic [SHIP_W-1:0]   ship_cnt;
   logic [GRID_W-1:0]   grid_cnt;
   logic                start_game_en;
   logic                ship_update_en;
   logic                grid_update_en;
   logic                game_over_q;
   logic                ship_wrap;
   logic                grid_wrap;

   // A held button yields exactly one rising edge.
   assign start_rise = bus.start & ~start_q;
   assign pause_rise = bus.pause & ~pause_q;

   assign ship_wrap = (ship_cnt == SHIP_MAX);
   assign grid_wrap = (grid_cnt == GRID_MAX);

   // Button history for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_q <= 1'b0;
         pause_q <= 1'b0;
      end else begin
         start_q <= bus.start;
         pause_q <= bus.pause;
      end
   end

   // Current-state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. In PLAY: health==0 beats pause, pause beats start.
   // In PAUSE a restart wins over a resume.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start_rise) next_state = START;
         end
         START: begin
            if (start_cnt == START_MAX) next_state = PLAY;
         end
         PLAY: begin
            if (bus.ship_health == 4'd0) next_state = OVER;
            else if (pause_rise)         next_state = PAUSE;
            else if (start_rise)         next_state = START;
         end
         PAUSE: begin
            if (start_rise)      next_state = START;
            else if (pause_rise) next_state = PLAY;
         end
         OVER: begin
            if (start_rise) next_state = START;
         end
         default: next_state = IDLE;
      endcase
   end

   // Cycles spent in START; restarts from zero on every entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_cnt <= '0;
      end else if (state == START) begin
         start_cnt <= start_cnt + START_W'(1);
      end else begin
         start_cnt <= '0;
      end
   end

   // Dividers: cleared in START, advance every PLAY cycle, hold otherwise so
   // a pause resumes the count where it stopped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ship_cnt <= '0;
         grid_cnt <= '0;
      end else if (state == START) begin
         ship_cnt <= '0;
         grid_cnt <= '0;
      end else if (state == PLAY) begin
         ship_cnt <= ship_wrap ? '0 : ship_cnt + SHIP_W'(1);
         grid_cnt <= grid_wrap ? '0 : grid_cnt + GRID_W'(1);
      end
   end

   // Registered strobes. Update pulses fire the cycle after a divider wrap,
   // but only if the machine stays in PLAY, so a pulse that would land in
   // PAUSE, OVER or START is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_game_en  <= 1'b0;
         ship_update_en <= 1'b0;
         grid_update_en <= 1'b0;
         game_over_q    <= 1'b0;
      end else begin
         start_game_en  <= (next_state == START);
         ship_update_en <= (state == PLAY) && (next_state == PLAY) && ship_wrap;
         grid_update_en <= (state == PLAY) && (next_state == PLAY) && grid_wrap;
         game_over_q    <= (next_state == OVER);
      end
   end

   assign bus.startGameEn  = start_game_en;
   assign bus.shipUpdateEn = ship_update_en;
   assign bus.gridUpdateEn = grid_update_en;
   assign bus.game_over    = game_over_q;
   assign bus.state        = state;

endmodule
